debounce_pulse: RTL and testbench

//  Conditions a raw, asynchronous push-button / switch input into clean single-cycle enable pulses.

---
 rtl/debounce_pulse.sv | 140 ++++++++++++++
 tb/tb_debounce_pulse.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Debounces a raw push-button input into a clean level plus one-cycle press/release pulses,
// with optional auto-repeat pulses while the button stays held.
module debounce_pulse #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 8,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE,
        S_HIGH,
        S_FALL
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_C     = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_C    = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam bit               REPEAT_EN   = (REPEAT_DELAY > 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rcnt_q;
    logic             repeating_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    logic [CNT_W-1:0] cntInc;
    logic [CNT_W-1:0] rcntInc;
    logic [CNT_W-1:0] repeatThr;
    logic             repeatFire;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // rcnt is compared one step ahead so the repeat pulse lands on the exact offset;
    // the !rise_q term keeps pulses from ever touching, even with a period of 1.
    always_comb begin
        cntInc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        rcntInc    = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CNT_ONE;
        repeatThr  = repeating_q ? PERIOD_C : DELAY_C;
        repeatFire = REPEAT_EN && (state_q == S_HIGH) && sync &&
                     (rcntInc >= repeatThr) && !rise_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOW;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            repeating_q <= 1'b0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                S_LOW: begin
                    if (sync) begin
                        state_q <= S_RISE;
                        cnt_q   <= CNT_ONE;
                    end
                end
                S_RISE: begin
                    if (!sync) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q >= STABLE_LAST) begin
                        state_q     <= S_HIGH;
                        level_q     <= 1'b1;
                        rise_q      <= 1'b1;
                        rcnt_q      <= '0;
                        repeating_q <= 1'b0;
                    end else begin
                        cnt_q <= cntInc;
                    end
                end
                S_HIGH: begin
                    if (!sync) begin
                        state_q <= S_FALL;
                        cnt_q   <= CNT_ONE;
                    end else if (repeatFire) begin
                        rise_q      <= 1'b1;
                        rcnt_q      <= '0;
                        repeating_q <= 1'b1;
                    end else if (REPEAT_EN) begin
                        rcnt_q <= rcntInc;
                    end
                end
                S_FALL: begin
                    // rcnt deliberately holds here so a short dip resumes the repeat cadence
                    if (sync) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q >= STABLE_LAST) begin
                        state_q     <= S_LOW;
                        cnt_q       <= '0;
                        level_q     <= 1'b0;
                        fall_q      <= 1'b1;
                        rcnt_q      <= '0;
                        repeating_q <= 1'b0;
                    end else begin
                        cnt_q <= cntInc;
                    end
                end
                default: begin
                    state_q <= S_LOW;
                end
            endcase
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: a default instance (A) and an auto-repeat instance (B)
// are driven by directed vectors; expected pulses are queued and matched by negedge monitors.
module tb_debounce_pulse;

    typedef struct {
        bit isRise;
        int cyc;
    } expEvt_t;

    logic clk = 1'b0;
    int   cyc = 0;

    logic rstA, btnA, levelA, riseA, fallA;
    logic rstB, btnB, levelB, riseB, fallB;

    expEvt_t queueA[$];
    expEvt_t queueB[$];
    expEvt_t evtA;
    expEvt_t evtB;

    int checks     = 0;
    int failures   = 0;
    int riseCountB = 0;

    debounce_pulse dutA (
        .clk        (clk),
        .rst        (rstA),
        .btn_in     (btnA),
        .level_out  (levelA),
        .rise_pulse (riseA),
        .fall_pulse (fallA)
    );

    debounce_pulse #(
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dutB (
        .clk        (clk),
        .rst        (rstB),
        .btn_in     (btnB),
        .level_out  (levelB),
        .rise_pulse (riseB),
        .fall_pulse (fallB)
    );

    // cyc holds the number of rising edges seen so far
    initial begin
        forever begin
            #500 clk = 1'b1;
            cyc++;
            #500 clk = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic waitUntil(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int atCyc, input bit onB, input logic rstVal,
                                 input logic btnVal);
        waitUntil(atCyc);
        if (onB) begin
            rstB = rstVal;
            btnB = btnVal;
        end else begin
            rstA = rstVal;
            btnA = btnVal;
        end
    endtask

    task automatic checkSignals(input int atCyc, input bit onB, input logic expLevel,
                                input logic expRise, input logic expFall);
        waitUntil(atCyc);
        if (clk === 1'b1) @(negedge clk);
        if (onB) begin
            checkOutput("levelB", levelB, expLevel);
            checkOutput("riseB", riseB, expRise);
            checkOutput("fallB", fallB, expFall);
        end else begin
            checkOutput("levelA", levelA, expLevel);
            checkOutput("riseA", riseA, expRise);
            checkOutput("fallA", fallA, expFall);
        end
    endtask

    task automatic expectPulse(input bit onB, input bit isRise, input int atCyc);
        expEvt_t e;
        e.isRise = isRise;
        e.cyc    = atCyc;
        if (onB) queueB.push_back(e);
        else     queueA.push_back(e);
    endtask

    always @(negedge clk) begin
        if (riseA === 1'b1 || fallA === 1'b1) begin
            if (queueA.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedA at cycle %0d: rise=%0d fall=%0d, expected no pulse",
                         cyc, riseA, fallA);
            end else begin
                evtA = queueA.pop_front();
                checkOutput("pulseA_kind", {31'd0, riseA}, {31'd0, evtA.isRise});
                checkOutput("pulseA_cycle", cyc, evtA.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (riseB === 1'b1) riseCountB++;
        if (riseB === 1'b1 || fallB === 1'b1) begin
            if (queueB.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedB at cycle %0d: rise=%0d fall=%0d, expected no pulse",
                         cyc, riseB, fallB);
            end else begin
                evtB = queueB.pop_front();
                checkOutput("pulseB_kind", {31'd0, riseB}, {31'd0, evtB.isRise});
                checkOutput("pulseB_cycle", cyc, evtB.cyc);
            end
        end
    end

    initial begin
        logic [5:0] bounce;
        int         offs[7];

        rstA = 1'b1;
        btnA = 1'b1;
        rstB = 1'b1;
        btnB = 1'b0;

        // Reset held over three edges with the button already pressed
        expectPulse(0, 1'b1, 9);
        expectPulse(0, 1'b0, 18);
        for (int c = 1; c <= 3; c++) checkSignals(c, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, 0, 1'b0, 1'b1);
        applyStimulus(3, 1, 1'b0, 1'b0);
        checkSignals(8, 0, 1'b0, 1'b0, 1'b0);
        checkSignals(9, 0, 1'b1, 1'b1, 1'b0);
        checkSignals(10, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(12, 0, 1'b0, 1'b0);
        checkSignals(17, 0, 1'b1, 1'b0, 1'b0);
        checkSignals(18, 0, 1'b0, 1'b0, 1'b1);

        // Clean 20-cycle press
        expectPulse(0, 1'b1, 36);
        expectPulse(0, 1'b0, 56);
        applyStimulus(30, 0, 1'b0, 1'b1);
        checkSignals(35, 0, 1'b0, 1'b0, 1'b0);
        checkSignals(36, 0, 1'b1, 1'b1, 1'b0);
        checkSignals(37, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(50, 0, 1'b0, 1'b0);
        checkSignals(55, 0, 1'b1, 1'b0, 1'b0);
        checkSignals(56, 0, 1'b0, 1'b0, 1'b1);

        // Bounce 1,0,1,1,0,1 then hold; last rising step is at cycle 75
        bounce = 6'b101101;
        expectPulse(0, 1'b1, 81);
        expectPulse(0, 1'b0, 96);
        for (int i = 0; i < 6; i++) applyStimulus(70 + i, 0, 1'b0, bounce[i]);
        checkSignals(77, 0, 1'b0, 1'b0, 1'b0);
        checkSignals(80, 0, 1'b0, 1'b0, 1'b0);
        checkSignals(81, 0, 1'b1, 1'b1, 1'b0);
        applyStimulus(90, 0, 1'b0, 1'b0);
        checkSignals(96, 0, 1'b0, 1'b0, 1'b1);

        // Three-cycle glitch must be ignored
        applyStimulus(110, 0, 1'b0, 1'b1);
        applyStimulus(113, 0, 1'b0, 1'b0);
        checkSignals(116, 0, 1'b0, 1'b0, 1'b0);
        checkSignals(120, 0, 1'b0, 1'b0, 1'b0);

        // Auto-repeat: press accepted at 136, repeats at +10 then every 4
        offs = '{0, 10, 14, 18, 22, 26, 30};
        for (int i = 0; i < 7; i++) expectPulse(1, 1'b1, 136 + offs[i]);
        expectPulse(1, 1'b0, 172);
        applyStimulus(130, 1, 1'b0, 1'b1);
        checkSignals(135, 1, 1'b0, 1'b0, 1'b0);
        checkSignals(136, 1, 1'b1, 1'b1, 1'b0);
        checkSignals(137, 1, 1'b1, 1'b0, 1'b0);
        checkSignals(145, 1, 1'b1, 1'b0, 1'b0);
        checkSignals(146, 1, 1'b1, 1'b1, 1'b0);
        applyStimulus(166, 1, 1'b0, 1'b0);
        checkSignals(172, 1, 1'b0, 1'b0, 1'b1);
        waitUntil(175);
        checkOutput("riseCountB_repeat", riseCountB, 7);

        // Reset pulse at offset 15 of a held press; detection and repeat restart
        expectPulse(1, 1'b1, 196);
        expectPulse(1, 1'b1, 206);
        expectPulse(1, 1'b1, 210);
        expectPulse(1, 1'b1, 218);
        expectPulse(1, 1'b1, 228);
        expectPulse(1, 1'b1, 232);
        expectPulse(1, 1'b0, 238);
        applyStimulus(190, 1, 1'b0, 1'b1);
        checkSignals(211, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(211, 1, 1'b1, 1'b1);
        checkSignals(212, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(212, 1, 1'b0, 1'b1);
        checkSignals(217, 1, 1'b0, 1'b0, 1'b0);
        checkSignals(218, 1, 1'b1, 1'b1, 1'b0);
        checkSignals(227, 1, 1'b1, 1'b0, 1'b0);
        checkSignals(228, 1, 1'b1, 1'b1, 1'b0);
        applyStimulus(232, 1, 1'b0, 1'b0);
        checkSignals(238, 1, 1'b0, 1'b0, 1'b1);

        waitUntil(250);
        checkOutput("riseCountB_total", riseCountB, 13);
        checkOutput("queueA_drained", queueA.size(), 0);
        checkOutput("queueB_drained", queueB.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
